// File: rtl/param_down_counter.sv
// param_down_counter: parametrised up/down counter with synchronous load,
// count enable and four terminal-count modes (wrap, saturate, auto-reload,
// one-shot). Registered terminal-count flag for downstream timers.
// Optional prescaler enabled by defining PARAM_DOWN_COUNTER_PRESCALE_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | counting allowed, busy=1
// HOLD  | one-shot expired at terminal count, waiting for load/reset
module param_down_counter #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b1}},
    parameter int unsigned           PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_RELOAD = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] term;
    logic             step_tick;

`ifdef PARAM_DOWN_COUNTER_PRESCALE_EN
    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q;

    assign step_tick = (psc_q == PSC_LAST);

    // Prescaler: counts enabled, non-load cycles in RUN; wraps on its tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
        end else if (load) begin
            psc_q <= '0;
        end else if (en && (state_q == ST_RUN)) begin
            if (step_tick) psc_q <= '0;
            else           psc_q <= psc_q + {{(PSC_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign step_tick = 1'b1;
`endif

    // State, count, reload value and terminal-count flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            count_q  <= RESET_VAL;
            reload_q <= RESET_VAL;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state: load beats step beats idle; tc only set on a step at term.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        term     = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = ST_RUN;
        end else if (en && (state_q == ST_RUN) && step_tick) begin
            if (count_q != term) begin
                count_d = dir ? (count_q + ONE) : (count_q - ONE);
            end else begin
                tc_d = 1'b1;
                case (mode)
                    MODE_WRAP:    count_d = dir ? (count_q + ONE) : (count_q - ONE);
                    MODE_SAT:     count_d = count_q;
                    MODE_RELOAD:  count_d = reload_q;
                    MODE_ONESHOT: state_d = ST_HOLD;
                    default:      count_d = count_q;
                endcase
            end
        end else if ((state_q == ST_HOLD) && (mode != MODE_ONESHOT)) begin
            // Leaving one-shot mode releases HOLD without touching the count.
            state_d = ST_RUN;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_param_down_counter.sv
// Directed self-checking bench for param_down_counter.
// Three instances: 4-bit and 8-bit with PRESCALE=1 (no prescale effect in
// either build), and an 8-bit PRESCALE=4 instance for the prescaler check.
module tb_param_down_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] load_val4;
    logic [7:0] load_val8;

    logic [3:0] count4;
    logic       tc4, busy4;
    logic [7:0] count8;
    logic       tc8, busy8;
    logic [7:0] count_p;
    logic       tc_p, busy_p;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PARAM_DOWN_COUNTER_PRESCALE_EN
    localparam int P_EFF = 4;
`else
    localparam int P_EFF = 1;
`endif

    param_down_counter #(.WIDTH(4), .PRESCALE(1)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val4),
        .dir(dir), .mode(mode), .count(count4), .tc(tc4), .busy(busy4)
    );

    param_down_counter #(.WIDTH(8), .PRESCALE(1)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val8),
        .dir(dir), .mode(mode), .count(count8), .tc(tc8), .busy(busy8)
    );

    param_down_counter #(.WIDTH(8), .PRESCALE(4)) u_dutp (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val8),
        .dir(dir), .mode(mode), .count(count_p), .tc(tc_p), .busy(busy_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load8(input logic [7:0] v);
        load      = 1'b1;
        load_val8 = v;
        tick();
        load      = 1'b0;
    endtask

    logic [7:0] t3_cnt [8] = '{8'h2, 8'h1, 8'h0, 8'h3, 8'h2, 8'h1, 8'h0, 8'h3};
    logic       t3_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       t6_en  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int         psc_m;
        logic [7:0] cnt_m;

        reset     = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        dir       = 1'b0;
        mode      = 2'b00;
        load_val4 = 4'h0;
        load_val8 = 8'h00;

        // Reset state
        tick();
        chk("rst_count4", count4, 32'hF);
        chk("rst_tc4",    tc4,    32'h0);
        chk("rst_busy4",  busy4,  32'h1);
        chk("rst_count8", count8, 32'hFF);

        // 1: 4-bit wrap down F..0 then F with one tc pulse
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("t1_count", count4, 32'((16 + 15 - i) % 16));
            chk("t1_tc",    tc4,    (i == 16) ? 32'h1 : 32'h0);
            chk("t1_busy",  busy4,  32'h1);
        end

        // 2: saturate up from FD
        en   = 1'b0;
        mode = 2'b01;
        dir  = 1'b1;
        do_load8(8'hFD);
        chk("t2_load", count8, 32'hFD);
        en = 1'b1;
        tick(); chk("t2_c1", count8, 32'hFE); chk("t2_tc1", tc8, 32'h0);
        tick(); chk("t2_c2", count8, 32'hFF); chk("t2_tc2", tc8, 32'h0);
        tick(); chk("t2_c3", count8, 32'hFF); chk("t2_tc3", tc8, 32'h1);
        tick(); chk("t2_c4", count8, 32'hFF); chk("t2_tc4", tc8, 32'h1);
        en = 1'b0;
        tick(); chk("t2_c5", count8, 32'hFF); chk("t2_tc5", tc8, 32'h0);

        // 3: auto-reload down from 3
        mode = 2'b10;
        dir  = 1'b0;
        do_load8(8'h03);
        chk("t3_load", count8, 32'h3);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_count", count8, 32'(t3_cnt[i]));
            chk("t3_tc",    tc8,    32'(t3_tc[i]));
        end

        // 4: one-shot down from 2
        en   = 1'b0;
        mode = 2'b11;
        do_load8(8'h02);
        chk("t4_load_busy", busy8, 32'h1);
        en = 1'b1;
        tick(); chk("t4_c1", count8, 32'h1); chk("t4_b1", busy8, 32'h1);
        tick(); chk("t4_c2", count8, 32'h0); chk("t4_tc2", tc8, 32'h0);
        tick(); chk("t4_c3", count8, 32'h0); chk("t4_tc3", tc8, 32'h1); chk("t4_b3", busy8, 32'h0);
        tick(); chk("t4_c4", count8, 32'h0); chk("t4_tc4", tc8, 32'h0); chk("t4_b4", busy8, 32'h0);
        tick(); chk("t4_b5", busy8, 32'h0);
        // Switching out of one-shot releases HOLD without a count change
        mode = 2'b00;
        tick(); chk("t4_rel_b", busy8, 32'h1); chk("t4_rel_c", count8, 32'h0); chk("t4_rel_tc", tc8, 32'h0);
        tick(); chk("t4_wrap_c", count8, 32'hFF); chk("t4_wrap_tc", tc8, 32'h1);
        // Back into one-shot, reload 5
        mode = 2'b11;
        en   = 1'b0;
        do_load8(8'h05);
        chk("t4_l5_c", count8, 32'h5); chk("t4_l5_b", busy8, 32'h1);
        en = 1'b1;
        tick(); chk("t4_l5_c1", count8, 32'h4);
        tick(); chk("t4_l5_c2", count8, 32'h3);

        // 5: load wins over en on the same edge
        mode = 2'b00;
        en   = 1'b0;
        do_load8(8'h07);
        chk("t5_seven", count8, 32'h7);
        en        = 1'b1;
        load      = 1'b1;
        load_val8 = 8'h0A;
        tick();
        load = 1'b0;
        chk("t5_ld_en", count8, 32'hA);
        chk("t5_ld_tc", tc8, 32'h0);
        tick(); chk("t5_step", count8, 32'h9);
        // Saturate at 0 so tc is high when reset hits
        mode = 2'b01;
        do_load8(8'h01);
        tick(); chk("t5_s0", count8, 32'h0);
        tick(); chk("t5_stc", tc8, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_arst_c8", count8, 32'hFF);
        chk("t5_arst_tc", tc8,    32'h0);
        chk("t5_arst_c4", count4, 32'hF);
        chk("t5_arst_b",  busy8,  32'h1);
        en = 1'b0;
        #1;
        reset = 1'b0;

        // 6: prescaled instance (steps every PRESCALE enabled cycles when built with the prescaler)
        mode = 2'b00;
        dir  = 1'b0;
        do_load8(8'h05);
        chk("t6_load", count_p, 32'h5);
        psc_m = 0;
        cnt_m = 8'h05;
        for (int i = 0; i < 12; i++) begin
            en = t6_en[i];
            tick();
            if (t6_en[i]) begin
                if (psc_m == P_EFF - 1) begin
                    psc_m = 0;
                    cnt_m = cnt_m - 8'h01;
                end else begin
                    psc_m = psc_m + 1;
                end
            end
            chk("t6_count", count_p, 32'(cnt_m));
        end
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
